mem_port_ctrl: RTL and testbench
================================

// Module: mem_port_ctrl
// PURPOSE
//  Sole master of the 16-bit word SRAM: sits between the boot byte stream / Mano CPU and the SRAM's
//  we_n/addr/data_in/data_out pins. After reset it loads a program from a byte stream into SRAM from
//  address 0, then serves CPU read/write requests over a req/ack handshake, absorbing the SRAM's
//  one-cycle registered read latency.
// PARAMETERS
//  DEPTH   32  number of SRAM words; legal addresses 0..DEPTH-1
//  CPU_AW  12  CPU address width (Mano AR)
// PORTS
//  clk         in   1       system clock; all state updates on posedge
//  rst         in   1       synchronous, active-high reset
//  boot_valid  in   1       boot byte present
//  boot_byte   in   8       boot byte
//  boot_ready  out  1       byte accepted when boot_valid & boot_ready at posedge
//  boot_done   out  1       load finished; stays 1 until rst
//  load_err    out  1       sticky: count byte > DEPTH
//  cpu_req     in   1       request; accepted when cpu_req & cpu_ready at posedge
//  cpu_we      in   1       1 = write, 0 = read (sampled at accept)
//  cpu_addr    in   CPU_AW  word address (sampled at accept)
//  cpu_wdata   in   16      write data (sampled at accept)
//  cpu_ready   out  1       controller idle and able to accept
//  cpu_ack     out  1       one-cycle pulse: access complete
//  cpu_rdata   out  16      read data; valid with cpu_ack, held until next ack
//  cpu_err     out  1       pulses with cpu_ack when address was >= DEPTH
//  mem_we_n    out  1       to SRAM we_n, active low
//  mem_addr    out  16      to SRAM addr (zero-extended)
//  mem_din     out  16      to SRAM data_in
//  mem_dout    in   16      from SRAM data_out; valid one cycle after addr is presented
// BEHAVIOUR
//  - Reset: state=B_CNT; mem_we_n=1; mem_addr, mem_din, cpu_rdata = 0; cpu_ready, cpu_ack, cpu_err,
//    boot_done, load_err = 0. SRAM contents are not cleared.
//  - All mem_* outputs are registered. mem_we_n is low for exactly one cycle per write.
//  - Boot stream: count byte N, then N words, 2 bytes per word, high byte first.
//  - B_CNT (boot_ready=1): latch N. N==0 -> RUN with boot_done=1. N>DEPTH -> load_err=1, clamp N to
//    DEPTH, discard the surplus 2*(Nraw-DEPTH) bytes in B_SKIP (boot_ready=1), then RUN.
//  - B_HI (boot_ready=1): latch high byte. B_LO (boot_ready=1): latch low byte -> B_WR.
//  - B_WR (boot_ready=0): mem_we_n=0, mem_addr=ptr, mem_din={hi,lo}; ptr++; ptr==N -> RUN, else B_HI.
//  - RUN: cpu_ready=1, boot_ready=0 (late boot bytes stall, never accepted). On accept -> ACC.
//  - CPU requests are never accepted before boot_done (cpu_ready=0 during boot).
//  - ACC (cycle 1): drive mem_addr; if write and address in range, mem_we_n=0 with mem_din. -> CAP.
//  - CAP (cycle 2): latch mem_dout into cpu_rdata on reads. -> ACK.
//  - ACK (cycle 3): cpu_ack=1 -> RUN.
//  - Latency: accept edge -> cpu_ack 3 cycles. Max rate: one access per 4 cycles.
//  - Out of range (cpu_addr >= DEPTH): no write, no SRAM read; cpu_rdata=16'h0000; cpu_err=1 with ack.
//  - cpu_req held high after ack is treated as a new request in the next RUN cycle.
//  - A write completes even if rst is asserted in its ACC/B_WR cycle, because the SRAM samples
//    mem_we_n=0 at that same edge. After rst the controller restarts at B_CNT. A read is abandoned
//    and no ack is issued.
//  - ptr and N are $clog2(DEPTH)+1 bits wide, so N==DEPTH needs no wrap.
// STRUCTURE
//  - Package mano_mem_pkg: WORD_W=16, MEM_AW=16, state enum (B_CNT, B_HI, B_LO, B_WR, B_SKIP, RUN,
//    ACC, CAP, ACK).
//  - One sub-module, boot_word_asm: count/byte-pair assembler with skip counter. It hands a
//    {word, last} strobe to the main FSM.
// TESTING
//  1. Boot 03,12,34,AB,CD,00,07 -> words 0..2 = 1234, ABCD, 0007; boot_done=1; three we_n pulses.
//  2. After boot, read addr 1 -> cpu_ack 3 cycles after accept, cpu_rdata=ABCD, cpu_err=0.
//  3. Write addr 31 = BEEF, then read 31 -> BEEF. Write addr 32 -> cpu_err=1, no we_n pulse,
//     word 0 unchanged.
//  4. Boot count 00 -> boot_done the cycle after the count byte; cpu_req during boot stays unacked.
//  5. Boot count 0x22 (34) -> load_err=1; 32 words written; 4 surplus bytes consumed; RUN reached.
//  6. Assert rst in the CPU-write ACC cycle -> word written; outputs at reset values; re-boot works.

Source files
------------

// File: rtl/mano_mem_pkg.sv
// Shared types for the Mano CPU memory port: SRAM word/address widths and
// the controller state encoding used by both the top FSM and the boot assembler.
package mano_mem_pkg;

   localparam int WORD_W = 16;
   localparam int MEM_AW = 16;

   typedef enum logic [3:0] {
      B_CNT,
      B_HI,
      B_LO,
      B_WR,
      B_SKIP,
      RUN,
      ACC,
      CAP,
      ACK
   } state_t;

endpackage

// File: rtl/boot_word_asm.sv
// Boot stream datapath: latches the word count (clamped to DEPTH), pairs bytes
// into words high-byte first, tracks the write pointer and counts surplus bytes.
module boot_word_asm
   import mano_mem_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int PTR_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  state_t            state,
   input  logic              boot_valid,
   input  logic [7:0]        boot_byte,
   output logic              boot_ready,
   output logic              accept,
   output logic              cnt_zero,
   output logic              cnt_over,
   output logic [WORD_W-1:0] word,
   output logic [PTR_W-1:0]  ptr,
   output logic              last,
   output logic              skip_pending,
   output logic              skip_last
);

   localparam logic [8:0] DEPTH_EXT = 9'(DEPTH);

   logic [PTR_W-1:0] n;
   logic [7:0]       hi;
   logic [8:0]       skip;

   assign boot_ready   = state inside {B_CNT, B_HI, B_LO, B_SKIP};
   assign accept       = boot_valid && boot_ready;
   assign cnt_zero     = (boot_byte == 8'd0);
   assign cnt_over     = ({1'b0, boot_byte} > DEPTH_EXT);
   assign word         = {hi, boot_byte};
   // ptr holds the index of the word being assembled until B_WR advances it.
   assign last         = ((ptr + PTR_W'(1)) == n);
   assign skip_pending = (skip != 9'd0);
   assign skip_last    = (skip == 9'd1);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         n    <= '0;
         ptr  <= '0;
         hi   <= '0;
         skip <= '0;
      end else begin
         case (state)
            B_CNT: if (accept) begin
               ptr  <= '0;
               n    <= cnt_over ? PTR_W'(DEPTH) : PTR_W'(boot_byte);
               skip <= cnt_over ? (({1'b0, boot_byte} - DEPTH_EXT) << 1) : 9'd0;
            end
            B_HI:    if (accept) hi <= boot_byte;
            B_WR:    ptr <= ptr + PTR_W'(1);
            B_SKIP:  if (accept) skip <= skip - 9'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/mem_port_ctrl.sv
// Sole SRAM master: loads the boot image after reset, then serves CPU
// read/write requests with a fixed ACC/CAP/ACK sequence around the SRAM read latency.
module mem_port_ctrl
   import mano_mem_pkg::*;
#(
   parameter int DEPTH  = 32,
   parameter int CPU_AW = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              boot_valid,
   input  logic [7:0]        boot_byte,
   output logic              boot_ready,
   output logic              boot_done,
   output logic              load_err,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [CPU_AW-1:0] cpu_addr,
   input  logic [WORD_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic              cpu_ack,
   output logic [WORD_W-1:0] cpu_rdata,
   output logic              cpu_err,
   output logic              mem_we_n,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_din,
   input  logic [WORD_W-1:0] mem_dout
);

   localparam int PTR_W = $clog2(DEPTH) + 1;

   state_t            state;
   logic              accept;
   logic              cnt_zero;
   logic              cnt_over;
   logic [WORD_W-1:0] word;
   logic [PTR_W-1:0]  ptr;
   logic              last;
   logic              skip_pending;
   logic              skip_last;
   logic              req_we;
   logic              req_ok;
   logic              in_range;

   boot_word_asm #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_asm (
      .clk          (clk),
      .rst          (rst),
      .state        (state),
      .boot_valid   (boot_valid),
      .boot_byte    (boot_byte),
      .boot_ready   (boot_ready),
      .accept       (accept),
      .cnt_zero     (cnt_zero),
      .cnt_over     (cnt_over),
      .word         (word),
      .ptr          (ptr),
      .last         (last),
      .skip_pending (skip_pending),
      .skip_last    (skip_last)
   );

   assign cpu_ready = (state == RUN);
   assign in_range  = (32'(cpu_addr) < 32'(DEPTH));

   always_ff @(posedge clk) begin
      // NOTE: only the controller is reset; the external SRAM keeps its
      // contents, and a write whose we_n edge coincides with rst still lands.
      if (rst) begin
         state     <= B_CNT;
         mem_we_n  <= 1'b1;
         mem_addr  <= '0;
         mem_din   <= '0;
         cpu_rdata <= '0;
         cpu_ack   <= 1'b0;
         cpu_err   <= 1'b0;
         boot_done <= 1'b0;
         load_err  <= 1'b0;
         req_we    <= 1'b0;
         req_ok    <= 1'b0;
      end else begin
         // Pulse outputs default inactive so each is high for exactly one cycle.
         mem_we_n <= 1'b1;
         cpu_ack  <= 1'b0;
         cpu_err  <= 1'b0;
         case (state)
            B_CNT: if (accept) begin
               if (cnt_over) load_err <= 1'b1;
               if (cnt_zero) begin
                  state     <= RUN;
                  boot_done <= 1'b1;
               end else begin
                  state <= B_HI;
               end
            end
            B_HI: if (accept) state <= B_LO;
            B_LO: if (accept) begin
               state    <= B_WR;
               mem_we_n <= 1'b0;
               mem_addr <= MEM_AW'(ptr);
               mem_din  <= word;
            end
            B_WR: begin
               if (!last) begin
                  state <= B_HI;
               end else if (skip_pending) begin
                  state <= B_SKIP;
               end else begin
                  state     <= RUN;
                  boot_done <= 1'b1;
               end
            end
            B_SKIP: if (accept && skip_last) begin
               state     <= RUN;
               boot_done <= 1'b1;
            end
            RUN: if (cpu_req) begin
               state  <= ACC;
               req_we <= cpu_we;
               req_ok <= in_range;
               if (in_range) begin
                  mem_addr <= MEM_AW'(cpu_addr);
                  if (cpu_we) begin
                     mem_we_n <= 1'b0;
                     mem_din  <= cpu_wdata;
                  end
               end
            end
            ACC: state <= CAP;
            CAP: begin
               // SRAM read data for the address driven in ACC is valid now.
               state   <= ACK;
               cpu_ack <= 1'b1;
               cpu_err <= !req_ok;
               if (!req_ok)     cpu_rdata <= '0;
               else if (!req_we) cpu_rdata <= mem_dout;
            end
            ACK:     state <= RUN;
            default: state <= B_CNT;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl: behavioural SRAM model, boot stream
// driver, and a scoreboard of expected CPU acks with latency checks.
module tb_mem_port_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        boot_valid = 1'b0;
   logic [7:0]  boot_byte = 8'h00;
   logic        boot_ready;
   logic        boot_done;
   logic        load_err;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [11:0] cpu_addr = 12'h000;
   logic [15:0] cpu_wdata = 16'h0000;
   logic        cpu_ready;
   logic        cpu_ack;
   logic [15:0] cpu_rdata;
   logic        cpu_err;
   logic        mem_we_n;
   logic [15:0] mem_addr;
   logic [15:0] mem_din;
   logic [15:0] mem_dout = 16'h0000;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      logic        chk_rd;
      int          acc_cycle;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [15:0] sram[32];
   int          total = 0;
   int          bad = 0;
   int          cycle = 0;
   int          we_cnt = 0;
   int          we_base;

   mem_port_ctrl #(.DEPTH(32), .CPU_AW(12)) dut (
      .clk        (clk),
      .rst        (rst),
      .boot_valid (boot_valid),
      .boot_byte  (boot_byte),
      .boot_ready (boot_ready),
      .boot_done  (boot_done),
      .load_err   (load_err),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_ready  (cpu_ready),
      .cpu_ack    (cpu_ack),
      .cpu_rdata  (cpu_rdata),
      .cpu_err    (cpu_err),
      .mem_we_n   (mem_we_n),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 32; i++) sram[i] = 16'h0000;
   end

   always @(posedge clk) begin
      cycle <= cycle + 1;
      if (!mem_we_n) sram[mem_addr[4:0]] <= mem_din;
      mem_dout <= sram[mem_addr[4:0]];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Scoreboard monitor: every ack must match the oldest outstanding request.
   always @(negedge clk) begin
      if (!mem_we_n) we_cnt++;
      if (cpu_ack) begin
         if (sb.size() == 0) begin
            check("unexpected_ack", 32'(cpu_ack), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("ack_latency", 32'(cycle - mon_e.acc_cycle), 32'd3);
            check("cpu_err", 32'(cpu_err), 32'(mon_e.err));
            if (mon_e.chk_rd) check("cpu_rdata", 32'(cpu_rdata), 32'(mon_e.rdata));
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit done = 0;
      @(negedge clk);
      boot_valid = 1'b1;
      boot_byte  = b;
      for (int i = 0; i < 50 && !done; i++) begin
         if (boot_ready) begin
            @(posedge clk);
            done = 1;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) check("boot_byte_timeout", 32'(done), 32'd1);
      #1 boot_valid = 1'b0;
   endtask

   task automatic cpu_access(input logic we, input logic [11:0] addr, input logic [15:0] wdata,
                             input logic [15:0] exp_rd, input logic exp_err, input logic chk_rd);
      exp_t e;
      bit   done = 0;
      @(negedge clk);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      for (int i = 0; i < 50 && !done; i++) begin
         if (cpu_ready) begin
            e.rdata = exp_rd; e.err = exp_err; e.chk_rd = chk_rd; e.acc_cycle = cycle;
            sb.push_back(e);
            @(posedge clk);
            done = 1;
         end else begin
            @(negedge clk);
         end
      end
      #1 cpu_req = 1'b0;
      if (!done) check("cpu_accept_timeout", 32'(done), 32'd1);
      for (int i = 0; i < 10 && sb.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (sb.size() != 0) begin
         check("ack_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   function automatic logic [15:0] pat(input int i);
      return 16'(i * 257) ^ 16'hA55A;
   endfunction

   initial begin
      do_reset();
      @(negedge clk);
      // Reset state
      check("rst_we_n", 32'(mem_we_n), 32'd1);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_din", 32'(mem_din), 32'd0);
      check("rst_rdata", 32'(cpu_rdata), 32'd0);
      check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
      check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
      check("rst_cpu_err", 32'(cpu_err), 32'd0);
      check("rst_boot_done", 32'(boot_done), 32'd0);
      check("rst_load_err", 32'(load_err), 32'd0);
      check("rst_boot_ready", 32'(boot_ready), 32'd1);

      // Three-word boot image
      we_base = we_cnt;
      send_byte(8'h03);
      send_byte(8'h12); send_byte(8'h34);
      send_byte(8'hAB); send_byte(8'hCD);
      send_byte(8'h00); send_byte(8'h07);
      repeat (2) @(negedge clk);
      check("boot1_done", 32'(boot_done), 32'd1);
      check("boot1_we_pulses", 32'(we_cnt - we_base), 32'd3);
      check("boot1_w0", 32'(sram[0]), 32'h1234);
      check("boot1_w1", 32'(sram[1]), 32'hABCD);
      check("boot1_w2", 32'(sram[2]), 32'h0007);
      check("boot1_load_err", 32'(load_err), 32'd0);
      check("run_boot_ready", 32'(boot_ready), 32'd0);

      // CPU reads and writes, including the address boundary
      cpu_access(1'b0, 12'd1, 16'h0000, 16'hABCD, 1'b0, 1'b1);
      cpu_access(1'b1, 12'd31, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
      check("wr31_sram", 32'(sram[31]), 32'hBEEF);
      cpu_access(1'b0, 12'd31, 16'h0000, 16'hBEEF, 1'b0, 1'b1);
      we_base = we_cnt;
      cpu_access(1'b1, 12'd32, 16'hDEAD, 16'h0000, 1'b1, 1'b0);
      check("wr32_no_we", 32'(we_cnt - we_base), 32'd0);
      check("wr32_w0_kept", 32'(sram[0]), 32'h1234);
      cpu_access(1'b0, 12'd40, 16'h0000, 16'h0000, 1'b1, 1'b1);
      cpu_access(1'b0, 12'd0, 16'h0000, 16'h1234, 1'b0, 1'b1);

      // Empty boot image; requests during boot are ignored
      do_reset();
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd0;
      for (int i = 0; i < 6; i++) begin
         check("boot_cpu_ready", 32'(cpu_ready), 32'd0);
         @(negedge clk);
      end
      cpu_req = 1'b0;
      send_byte(8'h00);
      check("zero_boot_done", 32'(boot_done), 32'd1);
      check("zero_cpu_ready", 32'(cpu_ready), 32'd1);
      check("zero_load_err", 32'(load_err), 32'd0);

      // Oversized count: 34 words announced, 32 stored, 4 bytes discarded
      do_reset();
      we_base = we_cnt;
      send_byte(8'h22);
      check("over_load_err", 32'(load_err), 32'd1);
      for (int i = 0; i < 32; i++) begin
         send_byte(pat(i)[15:8]);
         send_byte(pat(i)[7:0]);
      end
      for (int i = 0; i < 4; i++) begin
         send_byte(8'hEE);
         if (i == 2) check("over_done_early", 32'(boot_done), 32'd0);
      end
      check("over_boot_done", 32'(boot_done), 32'd1);
      check("over_cpu_ready", 32'(cpu_ready), 32'd1);
      check("over_we_pulses", 32'(we_cnt - we_base), 32'd32);
      for (int i = 0; i < 32; i++) check("over_word", 32'(sram[i]), 32'(pat(i)));
      @(negedge clk);
      boot_valid = 1'b1; boot_byte = 8'h55;
      repeat (3) begin
         @(negedge clk);
         check("late_byte_stall", 32'(boot_ready), 32'd0);
      end
      boot_valid = 1'b0;
      cpu_access(1'b0, 12'd31, 16'h0000, pat(31), 1'b0, 1'b1);

      // Reset during the ACC cycle of a CPU write
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'd5; cpu_wdata = 16'hF00D;
      for (int i = 0; i < 20 && !cpu_ready; i++) @(negedge clk);
      check("acc_rst_ready", 32'(cpu_ready), 32'd1);
      @(posedge clk);
      #1 cpu_req = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("acc_rst_word", 32'(sram[5]), 32'hF00D);
      check("acc_rst_we_n", 32'(mem_we_n), 32'd1);
      check("acc_rst_addr", 32'(mem_addr), 32'd0);
      check("acc_rst_ready0", 32'(cpu_ready), 32'd0);
      check("acc_rst_done", 32'(boot_done), 32'd0);
      check("acc_rst_lerr", 32'(load_err), 32'd0);
      check("acc_rst_boot_ready", 32'(boot_ready), 32'd1);
      rst = 1'b0;
      send_byte(8'h01);
      send_byte(8'h11); send_byte(8'h22);
      repeat (2) @(negedge clk);
      check("reboot_done", 32'(boot_done), 32'd1);
      check("reboot_w0", 32'(sram[0]), 32'h1122);
      cpu_access(1'b0, 12'd0, 16'h0000, 16'h1122, 1'b0, 1'b1);
      cpu_access(1'b0, 12'd5, 16'h0000, 16'hF00D, 1'b0, 1'b1);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
